// File: rtl/dac_player_pkg.sv
// Shared definitions for the DAC pattern player: register map, CTRL bits,
// FSM state encodings and the Wishbone byte-enable merge helper.
package dac_player_pkg;

    // Register byte offsets (pattern memory lives at 0x1000-0x1FFF)
    localparam logic [12:0] REG_CTRL   = 13'h000;
    localparam logic [12:0] REG_LENGTH = 13'h004;
    localparam logic [12:0] REG_STATUS = 13'h008;

    // CTRL bit indices
    localparam int CTRL_RUN     = 0;
    localparam int CTRL_ONESHOT = 1;

    // Wishbone access FSM
    localparam logic [1:0] WB_IDLE = 2'd0;
    localparam logic [1:0] WB_WAIT = 2'd1;
    localparam logic [1:0] WB_ACK  = 2'd2;

    // Player FSM
    localparam logic [1:0] PL_IDLE  = 2'd0;
    localparam logic [1:0] PL_PRIME = 2'd1;
    localparam logic [1:0] PL_PLAY  = 2'd2;

    // Captured Wishbone request, held for the WAIT cycle
    typedef struct packed {
        logic        we;
        logic [12:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wb_req_t;

    // Merge write data into an old 32-bit value under byte enables
    function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  sel);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++)
            if (sel[i]) r[8*i +: 8] = wdat[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/dac_player_ram.sv
// Simple dual-port pattern RAM: byte-enabled write port, registered read
// port with 1-cycle latency and read-first behaviour. Contents survive reset.
module dac_player_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 128
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   wbe_i,
    input  logic                  re_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);
    logic [DATA_W-1:0] mem_q [0:2**ADDR_W-1];
    logic [DATA_W-1:0] rdata_q;

    // Byte-masked write plus registered read; the read samples pre-write data
    always_ff @(posedge clk_i) begin
        if (we_i)
            for (int i = 0; i < DATA_W/8; i++)
                if (wbe_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        if (re_i)
            rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dac_pattern_player.sv
// DAC pattern player: Wishbone-programmed pattern memory replayed as an
// AXI4-Stream of 128-bit beats, looping or one-shot.
module dac_pattern_player
    import dac_player_pkg::*;
#(
    parameter int NBEAT_LOG2   = 8,
    parameter int SAMPLE_WIDTH = 128
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [12:0]             wb_adr_i,
    input  logic [31:0]             wb_dat_i,
    input  logic [3:0]              wb_sel_i,
    output logic                    wb_ack_o,
    output logic [31:0]             wb_dat_o,
    output logic [SAMPLE_WIDTH-1:0] dac0_tdata,
    output logic                    dac0_tvalid,
    input  logic                    dac0_tready
);
    localparam int NBYTES = SAMPLE_WIDTH / 8;
    typedef logic [NBEAT_LOG2-1:0] beat_t;

    function automatic beat_t next_beat(input beat_t cur, input beat_t last);
        return (cur == last) ? '0 : cur + 1'b1;
    endfunction

    // ---------------- Wishbone side ----------------
    logic [1:0]        wb_st_q, wb_st_d;
    wb_req_t           req_q;
    logic              ack_q;
    logic [31:0]       dat_q, rd_val;
    logic [1:0]        ctrl_q, ctrl_d;
    beat_t             len_q, len_d;
    logic [31:0]       ctrl_wval, len_wval;
    logic              wb_wr, is_mem, mem_we;
    logic [1:0]        lane;
    logic [NBYTES-1:0] mem_wbe;
    logic [SAMPLE_WIDTH-1:0] mem_wdata, wb_rdata, pl_rdata;

    // ---------------- Player side ----------------
    logic [1:0]  pl_st_q, pl_st_d;
    beat_t       last_q, out_idx_q, pf_idx_q, last_eff, rd_addr;
    logic [15:0] loopcnt_q;
    logic        run_prev_q, start_q;
    logic [SAMPLE_WIDTH-1:0] tdata_q;
    logic        tvalid_q, accept, at_last, run, oneshot, oneshot_done, stop, rd_re, playing;

    assign is_mem    = req_q.adr[12];
    assign lane      = req_q.adr[3:2];
    assign wb_wr     = (wb_st_q == WB_WAIT) && req_q.we;
    assign mem_we    = wb_wr && is_mem;
    assign mem_wbe   = NBYTES'(req_q.sel) << {lane, 2'b00};
    assign mem_wdata = {(SAMPLE_WIDTH/32){req_q.dat}};
    assign ctrl_wval = apply_sel({30'b0, ctrl_q}, req_q.dat, req_q.sel);
    assign len_wval  = apply_sel(32'(len_q), req_q.dat, req_q.sel);

    assign run     = ctrl_q[CTRL_RUN];
    assign oneshot = ctrl_q[CTRL_ONESHOT];
    assign playing = (pl_st_q == PL_PRIME) || (pl_st_q == PL_PLAY);

    // Two copies of the pattern share the write port: one read port feeds the
    // stream, the other serves Wishbone readback so neither stalls the other.
    dac_player_ram #(.ADDR_W(NBEAT_LOG2), .DATA_W(SAMPLE_WIDTH)) u_ram_play (
        .clk_i(wb_clk_i), .we_i(mem_we), .waddr_i(req_q.adr[4 +: NBEAT_LOG2]),
        .wdata_i(mem_wdata), .wbe_i(mem_wbe),
        .re_i(rd_re), .raddr_i(rd_addr), .rdata_o(pl_rdata)
    );
    dac_player_ram #(.ADDR_W(NBEAT_LOG2), .DATA_W(SAMPLE_WIDTH)) u_ram_wb (
        .clk_i(wb_clk_i), .we_i(mem_we), .waddr_i(req_q.adr[4 +: NBEAT_LOG2]),
        .wdata_i(mem_wdata), .wbe_i(mem_wbe),
        .re_i(wb_st_q == WB_IDLE), .raddr_i(wb_adr_i[4 +: NBEAT_LOG2]), .rdata_o(wb_rdata)
    );

    // Wishbone next state: IDLE accepts, WAIT covers RAM latency, ACK is dead time
    always_comb begin
        wb_st_d = wb_st_q;
        case (wb_st_q)
            WB_IDLE: if (wb_cyc_i && wb_stb_i) wb_st_d = WB_WAIT;
            WB_WAIT: wb_st_d = WB_ACK;
            default: wb_st_d = WB_IDLE;
        endcase
    end

    // Read data mux for the captured address
    always_comb begin
        rd_val = '0;
        if (is_mem) rd_val = wb_rdata[{lane, 5'b0} +: 32];
        else begin
            case (req_q.adr)
                REG_CTRL:   rd_val = {30'b0, ctrl_q};
                REG_LENGTH: rd_val = 32'(len_q);
                REG_STATUS: rd_val = {loopcnt_q, 15'b0, playing};
                default:    rd_val = '0;
            endcase
        end
    end

    // Wishbone handshake: capture request, answer two cycles later
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_st_q <= WB_IDLE;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            req_q   <= '0;
        end else begin
            wb_st_q <= wb_st_d;
            ack_q   <= (wb_st_q == WB_WAIT);
            if (wb_st_q == WB_IDLE && wb_cyc_i && wb_stb_i)
                req_q <= '{we: wb_we_i, adr: wb_adr_i, dat: wb_dat_i, sel: wb_sel_i};
            if (wb_st_q == WB_WAIT)
                dat_q <= req_q.we ? '0 : rd_val;
        end
    end

    // CTRL/LENGTH next values; a finished one-shot leaves CTRL fully clear
    always_comb begin
        ctrl_d = ctrl_q;
        len_d  = len_q;
        if (wb_wr && !is_mem && req_q.adr == REG_CTRL)   ctrl_d = ctrl_wval[1:0];
        if (wb_wr && !is_mem && req_q.adr == REG_LENGTH) len_d  = len_wval[NBEAT_LOG2-1:0];
        if (oneshot_done) ctrl_d = '0;
    end

    // Control registers and RUN rising-edge detect
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ctrl_q     <= '0;
            len_q      <= '1;
            run_prev_q <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            len_q      <= len_d;
            run_prev_q <= run;
            start_q    <= run && !run_prev_q;
        end
    end

    // Player datapath helpers. The RAM output register is the prefetch stage:
    // it always holds the beat after the one on the bus, and only advances on
    // a handshake, so stalls hold both stages without losing a beat.
    assign accept       = tvalid_q && dac0_tready;
    assign at_last      = (out_idx_q == last_q);
    assign oneshot_done = (pl_st_q == PL_PLAY) && accept && at_last && oneshot;
    assign stop         = accept && ((at_last && oneshot) || !run);
    assign last_eff     = (accept && at_last) ? len_q : last_q;
    assign rd_addr      = (pl_st_q == PL_IDLE) ? '0 : next_beat(pf_idx_q, last_eff);
    assign rd_re        = ((pl_st_q == PL_IDLE) && start_q) || (pl_st_q == PL_PRIME) ||
                          ((pl_st_q == PL_PLAY) && accept);

    // Player next state
    always_comb begin
        pl_st_d = pl_st_q;
        case (pl_st_q)
            PL_IDLE:  if (start_q) pl_st_d = PL_PRIME;
            PL_PRIME: pl_st_d = run ? PL_PLAY : PL_IDLE;
            PL_PLAY:  if (stop) pl_st_d = PL_IDLE;
            default:  pl_st_d = PL_IDLE;
        endcase
    end

    // Player state, output beat register, beat indices and loop counter
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pl_st_q   <= PL_IDLE;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            loopcnt_q <= '0;
            last_q    <= '0;
            out_idx_q <= '0;
            pf_idx_q  <= '0;
        end else begin
            pl_st_q <= pl_st_d;
            case (pl_st_q)
                PL_IDLE: if (start_q) begin
                    last_q    <= len_q;
                    pf_idx_q  <= '0;
                    loopcnt_q <= '0;
                end
                PL_PRIME: if (run) begin
                    tvalid_q  <= 1'b1;
                    tdata_q   <= pl_rdata;
                    out_idx_q <= pf_idx_q;
                    pf_idx_q  <= rd_addr;
                end
                PL_PLAY: if (accept) begin
                    if (at_last && !oneshot) begin
                        loopcnt_q <= loopcnt_q + 16'd1;
                        last_q    <= len_q;
                    end
                    if (stop) begin
                        tvalid_q <= 1'b0;
                        tdata_q  <= '0;
                    end else begin
                        tdata_q   <= pl_rdata;
                        out_idx_q <= pf_idx_q;
                        pf_idx_q  <= rd_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wb_ack_o    = ack_q;
    assign wb_dat_o    = dat_q;
    assign dac0_tdata  = tdata_q;
    assign dac0_tvalid = tvalid_q;

endmodule

// File: tb/tb_dac_pattern_player.sv
// Scoreboard bench for dac_pattern_player: drivers queue expected Wishbone
// read data and stream beats; negedge monitors pop and compare.
module tb_dac_pattern_player;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [12:0]  wb_adr = '0;
    logic [31:0]  wb_dat = '0;
    logic [3:0]   wb_sel = '0;
    logic         wb_ack;
    logic [31:0]  wb_rdat;
    logic [127:0] tdata;
    logic         tvalid;
    logic         tready = 1'b0;

    always #5 clk = ~clk;

    dac_pattern_player dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel),
        .wb_ack_o(wb_ack), .wb_dat_o(wb_rdat),
        .dac0_tdata(tdata), .dac0_tvalid(tvalid), .dac0_tready(tready)
    );

    typedef struct { bit rd; logic [31:0] data; string nm; } wb_exp_t;

    wb_exp_t      wb_q[$];
    logic [127:0] beat_q[$];
    int           checks = 0, errors = 0;
    int           cyc_cnt = 0, last_ack_cyc = 0;
    logic         stall_q = 1'b0;
    logic [127:0] held_q = '0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk128(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] beat(input int b);
        logic [127:0] r;
        for (int l = 0; l < 4; l++) r[32*l +: 32] = {b[7:0], l[7:0], 16'hA5A5};
        return r;
    endfunction

    // Stream monitor: every handshake pops one expected beat; stalls must hold
    always @(negedge clk) begin
        if (rst) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q) begin
                chk32("stall tvalid held", 32'(tvalid), 32'd1);
                chk128("stall tdata held", tdata, held_q);
            end
            if (tvalid && tready) begin
                if (beat_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected beat: got %h expected none", tdata);
                end else begin
                    chk128("stream beat", tdata, beat_q.pop_front());
                end
            end
            stall_q <= tvalid && !tready;
            held_q  <= tdata;
        end
    end

    // Wishbone monitor: every ack pops one queued access
    always @(negedge clk) begin
        if (!rst && wb_ack) begin
            if (wb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected ack: got ack expected none");
            end else begin
                wb_exp_t e;
                e = wb_q.pop_front();
                if (e.rd) chk32(e.nm, wb_rdat, e.data);
            end
        end
    end

    // One Wishbone access; checks ack lands exactly 2 cycles after stb is seen
    task automatic wb_xfer(input bit we, input logic [12:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] exp, input string nm);
        int n;
        wb_exp_t e;
        e.rd = !we; e.data = exp; e.nm = nm;
        wb_q.push_back(e);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!wb_ack && n < 8);
        checks++;
        if (n != 2 || !wb_ack) begin
            errors++;
            $display("FAIL %s ack latency: got %0d cycles expected 2", nm, n);
        end
        last_ack_cyc = cyc_cnt;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [12:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        wb_xfer(1'b1, adr, dat, sel, 32'd0, "write");
    endtask

    task automatic rd(input logic [12:0] adr, input logic [31:0] exp, input string nm);
        wb_xfer(1'b0, adr, 32'd0, 4'hF, exp, nm);
    endtask

    task automatic wait_tvalid(input string nm, input int exp_dly);
        int n;
        n = 0;
        while (!tvalid && n < 20) begin @(posedge clk); #1; n++; end
        chk32({nm, " tvalid rise after ack"}, cyc_cnt - last_ack_cyc, exp_dly);
    endtask

    // Drive tready from a 4-cycle pattern until n beats are handed over
    task automatic stream(input int n, input logic [3:0] pat, output int cycles);
        int k, got;
        k = 0; got = 0;
        while (got < n && k < 400) begin
            tready = pat[k % 4];
            if (tvalid && tready) got++;
            k++;
            @(posedge clk); #1;
        end
        tready = 1'b0;
        cycles = k;
        chk32("beats handed over", got, n);
    endtask

    // Clear RUN while stalled, let the presented beat drain, expect idle bus
    task automatic stop_play(input logic [127:0] held);
        beat_q.push_back(held);
        wr(13'h000, 32'h0, 4'hF);
        tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tready = 1'b0;
        chk32("stopped tvalid", 32'(tvalid), 32'd0);
        chk128("stopped tdata", tdata, 128'd0);
        chk32("stream queue drained", beat_q.size(), 0);
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk32("reset tvalid", 32'(tvalid), 32'd0);
        chk128("reset tdata", tdata, 128'd0);
        chk32("reset ack", 32'(wb_ack), 32'd0);
        rd(13'h000, 32'h0, "reset CTRL");
        rd(13'h004, 32'h0000_00FF, "reset LENGTH");
        rd(13'h008, 32'h0, "reset STATUS");

        // Load beats 0..3
        for (int b = 0; b < 4; b++)
            for (int l = 0; l < 4; l++)
                wr(13'h1000 + 13'(16*b + 4*l), {b[7:0], l[7:0], 16'hA5A5}, 4'hF);
        rd(13'h1024, {8'd2, 8'd1, 16'hA5A5}, "mem readback b2l1");

        // Continuous loop, tready high
        wr(13'h004, 32'd3, 4'hF);
        wr(13'h000, 32'd1, 4'hF);
        wait_tvalid("loop", 3);
        for (int i = 0; i < 8; i++) beat_q.push_back(beat(i % 4));
        stream(8, 4'b1111, k);
        chk32("no gaps at full rate", k, 8);
        chk32("loop beats consumed", beat_q.size(), 0);
        rd(13'h008, 32'h0002_0001, "STATUS after 8 beats");
        stop_play(beat(0));

        // Backpressure 1,0,0,1
        wr(13'h000, 32'd1, 4'hF);
        wait_tvalid("stall", 3);
        for (int i = 0; i < 6; i++) beat_q.push_back(beat(i % 4));
        stream(6, 4'b1001, k);
        chk32("stall beats consumed", beat_q.size(), 0);
        stop_play(beat(2));

        // One-shot, 2 beats
        wr(13'h004, 32'd1, 4'hF);
        tready = 1'b1;
        beat_q.push_back(beat(0));
        beat_q.push_back(beat(1));
        wr(13'h000, 32'd3, 4'hF);
        repeat (12) @(posedge clk);
        #1;
        chk32("oneshot tvalid low", 32'(tvalid), 32'd0);
        chk32("oneshot beats consumed", beat_q.size(), 0);
        tready = 1'b0;
        rd(13'h000, 32'h0, "CTRL after oneshot");
        rd(13'h008, 32'h0, "STATUS after oneshot");

        // LENGTH shrunk to 0 during play
        wr(13'h004, 32'd3, 4'hF);
        wr(13'h000, 32'd1, 4'hF);
        wait_tvalid("shrink", 3);
        wr(13'h004, 32'd0, 4'hF);
        beat_q.push_back(beat(0)); beat_q.push_back(beat(1));
        beat_q.push_back(beat(2)); beat_q.push_back(beat(3));
        for (int i = 0; i < 4; i++) beat_q.push_back(beat(0));
        stream(8, 4'b1111, k);
        chk32("shrink beats consumed", beat_q.size(), 0);
        rd(13'h008, 32'h0005_0001, "STATUS after shrink");
        stop_play(beat(0));

        // Reset mid-play while stalled
        wr(13'h004, 32'd3, 4'hF);
        wr(13'h000, 32'd1, 4'hF);
        wait_tvalid("reset", 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk32("post-reset tvalid", 32'(tvalid), 32'd0);
        chk128("post-reset tdata", tdata, 128'd0);
        rd(13'h000, 32'h0, "CTRL after reset");
        rd(13'h008, 32'h0, "STATUS after reset");
        rd(13'h004, 32'h0000_00FF, "LENGTH after reset");
        rd(13'h1024, {8'd2, 8'd1, 16'hA5A5}, "mem kept b2l1");
        rd(13'h1030, {8'd3, 8'd0, 16'hA5A5}, "mem kept b3l0");

        // Byte enables, read-only and unmapped addresses
        wr(13'h1014, 32'hFFFF_FFFF, 4'hF);
        wr(13'h1014, 32'hDEAD_BEEF, 4'b0011);
        rd(13'h1014, 32'hFFFF_BEEF, "byte-enable merge");
        wr(13'h004, 32'h0000_0012, 4'b0000);
        rd(13'h004, 32'h0000_00FF, "LENGTH no sel");
        wr(13'h008, 32'hFFFF_FFFF, 4'hF);
        rd(13'h008, 32'h0, "STATUS write ignored");
        wr(13'h00C, 32'h1234_5678, 4'hF);
        rd(13'h00C, 32'h0, "unmapped read");

        repeat (2) @(posedge clk);
        #1;
        chk32("wb queue drained", wb_q.size(), 0);
        chk32("beat queue drained", beat_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
